// File: rtl/led_driver_pkg.sv
// Shared types and sizes for the LED driver output path.
package led_driver_pkg;

  localparam int NUM_LEDS  = 4;
  localparam int DUTY_BITS = 8;

  typedef enum logic [1:0] {LDR_OFF, LDR_ON, LDR_PWM, LDR_GRP} ledout_sel_t;
  typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_WAKE} sched_state_t;

endpackage

// File: rtl/led_tick_div.sv
// Free-running clock divider: one-cycle tick every DIV enabled cycles, clearable.
module led_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clr)    count <= '0;
    else if (en)     count <= (count == LAST) ? '0 : count + 1'b1;
  end

  assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/led_output_sched.sv
// LED output scheduler: individual PWM, group dim/blink and sleep/wake sequencing,
// producing registered LED pin levels from the mode/LEDOUT/duty registers.
module led_output_sched
  import led_driver_pkg::*;
#(
  parameter int PWM_DIV   = 4,
  parameter int BLINK_DIV = 2604,
  parameter int WAKE_CYC  = 500
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode_sleep,
  input  logic                                mode_dmblnk,
  input  logic                                mode_invrt,
  input  logic [2*NUM_LEDS-1:0]               ledout,
  input  logic [NUM_LEDS-1:0][DUTY_BITS-1:0]  pwm_duty,
  input  logic [DUTY_BITS-1:0]                grppwm,
  input  logic [DUTY_BITS-1:0]                grpfreq,
  output logic [NUM_LEDS-1:0]                 leds,
  output logic                                pwm_sync,
  output logic                                awake
);
  localparam int WW = $clog2(WAKE_CYC + 1);
  localparam logic [DUTY_BITS-1:0] CNT_MAX = '1;

  sched_state_t state, next_state;
  logic [WW-1:0] wake_cnt;
  logic run, enter_run;

  logic [DUTY_BITS-1:0] cnt, gcnt, phase, unit;
  logic [NUM_LEDS-1:0][DUTY_BITS-1:0] duty_sh;
  logic [DUTY_BITS-1:0] grppwm_sh, grpfreq_sh;
  logic dmblnk_q, toggled;
  logic pwm_step, pwm_wrap, sub_tick, unit_wrap, phase_wrap, grp;
  logic [NUM_LEDS-1:0] lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN:   if (mode_sleep) next_state = ST_SLEEP;
      ST_SLEEP: if (!mode_sleep) next_state = ST_WAKE;
      ST_WAKE: begin
        if (mode_sleep)                             next_state = ST_SLEEP;
        else if (wake_cnt == WW'(WAKE_CYC - 1))     next_state = ST_RUN;
      end
      default:  next_state = ST_RUN;
    endcase
  end

  always_comb begin
    run       = (state == ST_RUN);
    awake     = run;
    enter_run = (state == ST_WAKE) && (next_state == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wake_cnt <= '0;
    else if (state == ST_WAKE) wake_cnt <= wake_cnt + 1'b1;
    else                       wake_cnt <= '0;
  end

  assign toggled = (mode_dmblnk != dmblnk_q);

  led_tick_div #(.DIV(PWM_DIV)) u_pwm_div (
    .clk(clk), .reset(reset), .en(run), .clr(!run), .tick(pwm_step)
  );

  led_tick_div #(.DIV(BLINK_DIV)) u_blink_div (
    .clk(clk), .reset(reset), .en(run && mode_dmblnk), .clr(!run || toggled), .tick(sub_tick)
  );

  assign pwm_wrap   = pwm_step && (cnt == CNT_MAX);
  assign unit_wrap  = sub_tick && (unit == grpfreq_sh);
  assign phase_wrap = unit_wrap && (phase == CNT_MAX);

  // NOTE: shadows are plain registers, not RAM, so they take the async reset like any flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      gcnt       <= '0;
      phase      <= '0;
      unit       <= '0;
      pwm_sync   <= 1'b0;
      dmblnk_q   <= 1'b0;
      duty_sh    <= '0;
      grppwm_sh  <= '0;
      grpfreq_sh <= '0;
    end else begin
      dmblnk_q <= mode_dmblnk;
      if (!run) begin
        cnt      <= '0;
        gcnt     <= '0;
        phase    <= '0;
        unit     <= '0;
        pwm_sync <= 1'b0;
        if (enter_run) begin
          duty_sh    <= pwm_duty;
          grppwm_sh  <= grppwm;
          grpfreq_sh <= grpfreq;
        end
      end else begin
        pwm_sync <= pwm_wrap;
        if (pwm_step) cnt <= cnt + 1'b1;
        if (pwm_wrap) duty_sh <= pwm_duty;
        // Group duty follows the period boundary of whichever group mode is active.
        if ((!mode_dmblnk && pwm_wrap) || phase_wrap) grppwm_sh <= grppwm;
        if (phase_wrap) grpfreq_sh <= grpfreq;
        if (toggled) begin
          gcnt  <= '0;
          phase <= '0;
          unit  <= '0;
        end else if (!mode_dmblnk) begin
          if (pwm_wrap) gcnt <= gcnt + 1'b1;
        end else if (sub_tick) begin
          unit <= unit_wrap ? '0 : unit + 1'b1;
          if (unit_wrap) phase <= phase + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lvl = '0;
    grp = mode_dmblnk ? (phase < grppwm_sh) : (gcnt < grppwm_sh);
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (ledout_sel_t'(ledout[2*i +: 2]))
        LDR_OFF: lvl[i] = 1'b0;
        LDR_ON:  lvl[i] = 1'b1;
        LDR_PWM: lvl[i] = (cnt < duty_sh[i]);
        LDR_GRP: lvl[i] = (cnt < duty_sh[i]) && grp;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    leds <= '0;
    else if (run) leds <= lvl ^ {NUM_LEDS{mode_invrt}};
    else          leds <= {NUM_LEDS{mode_invrt}};
  end

endmodule
